// File: rtl/mac_mem_unit_if.sv
// Request/response bundle between the MEM stage and the multiply-accumulate unit.
// Latency: n/a (wiring only).
// Backpressure: mac_stall from the unit freezes the issuing pipeline stages.
interface mac_mem_unit_if #(
    parameter int XLEN = 32
);
    logic                mac_write_m;
    logic [1:0]          mac_op_m;      // 0 NONE, 1 MUL, 2 MACC, 3 CLR
    logic [XLEN-1:0]     src_a_m;
    logic [XLEN-1:0]     src_b_m;
    logic                mac_stall;
    logic                mac_busy;
    logic                mac_done;
    logic [2*XLEN-1:0]   mac_acc;
    logic                mac_ovf;

    // Pipeline side: issues requests, observes stall and results
    modport master (
        output mac_write_m, mac_op_m, src_a_m, src_b_m,
        input  mac_stall, mac_busy, mac_done, mac_acc, mac_ovf
    );

    // Unit side
    modport slave (
        input  mac_write_m, mac_op_m, src_a_m, src_b_m,
        output mac_stall, mac_busy, mac_done, mac_acc, mac_ovf
    );
endinterface

// File: rtl/mac_mem_unit.sv
// Signed shift-add multiply-accumulate for the MEM stage; optional MAC_SATURATE_EN saturates MACC.
// Latency: MUL/MACC XLEN+3 cycles (stall XLEN+2, result visible in DONE); CLR 1 cycle.
// Backpressure: combinational mac_stall holds F/D/E/M from request until ACC completes.
module mac_mem_unit #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    mac_mem_unit_if.slave  mac
);
    localparam int AW = 2 * XLEN;
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] OP_MUL  = 2'd1;
    localparam logic [1:0] OP_MACC = 2'd2;
    localparam logic [1:0] OP_CLR  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_DONE} state_t;

    state_t          state;
    logic [AW-1:0]   mcand;
    logic [AW-1:0]   prod;
    logic [AW-1:0]   acc;
    logic [XLEN-1:0] mplier;
    logic [CW-1:0]   cnt;
    logic            prod_neg;
    logic            op_macc;
    logic            busy_q;
    logic            done_q;

    logic            start;
    logic            clr_req;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [AW-1:0]   prod_signed;
    logic [AW-1:0]   macc_sum;
    logic [AW-1:0]   macc_res;
`ifdef MAC_SATURATE_EN
    logic            macc_ovf;
    logic            ovf_q;
`endif

    // Request decode and operand magnitudes; |-2^(XLEN-1)| fits exactly as unsigned
    always_comb begin
        start   = mac.mac_write_m && (mac.mac_op_m == OP_MUL || mac.mac_op_m == OP_MACC);
        clr_req = mac.mac_write_m && (mac.mac_op_m == OP_CLR);
        a_abs   = mac.src_a_m[XLEN-1] ? (~mac.src_a_m + 1'b1) : mac.src_a_m;
        b_abs   = mac.src_b_m[XLEN-1] ? (~mac.src_b_m + 1'b1) : mac.src_b_m;
    end

    // Signed product and accumulate, with overflow clamping when saturation is built in
    always_comb begin
        prod_signed = prod_neg ? (~prod + 1'b1) : prod;
        macc_sum    = acc + prod_signed;
`ifdef MAC_SATURATE_EN
        macc_ovf = (acc[AW-1] == prod_signed[AW-1]) && (macc_sum[AW-1] != acc[AW-1]);
        if (macc_ovf)
            macc_res = acc[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        else
            macc_res = macc_sum;
`else
        macc_res = macc_sum;
`endif
    end

    // Control FSM plus shift-add datapath; reset abandons any partial result
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            cnt      <= '0;
            prod_neg <= 1'b0;
            op_macc  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand    <= {{XLEN{1'b0}}, a_abs};
                        mplier   <= b_abs;
                        prod     <= '0;
                        cnt      <= '0;
                        prod_neg <= mac.src_a_m[XLEN-1] ^ mac.src_b_m[XLEN-1];
                        op_macc  <= (mac.mac_op_m == OP_MACC);
                        busy_q   <= 1'b1;
                        state    <= S_MUL;
                    end else if (clr_req) begin
                        acc <= '0;
                    end
                end
                S_MUL: begin
                    if (mplier[0])
                        prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(XLEN - 1))
                        state <= S_ACC;
                end
                S_ACC: begin
                    acc    <= op_macc ? macc_res : prod_signed;
                    done_q <= 1'b1;
                    state  <= S_DONE;
                end
                default: begin
                    // DONE: a request still held on the inputs is not restarted
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MAC_SATURATE_EN
    // Sticky overflow: set by a clamped MACC, cleared only by CLR or reset
    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (state == S_IDLE && !start && clr_req)
            ovf_q <= 1'b0;
        else if (state == S_ACC && op_macc && macc_ovf)
            ovf_q <= 1'b1;
    end
    assign mac.mac_ovf = ovf_q;
`else
    assign mac.mac_ovf = 1'b0;
`endif

    assign mac.mac_stall = !rst && ((state == S_IDLE && start) || state == S_MUL || state == S_ACC);
    assign mac.mac_busy  = busy_q;
    assign mac.mac_done  = done_q;
    assign mac.mac_acc   = acc;
endmodule

// File: tb/tb_mac_mem_unit.sv
// Self-checking bench for mac_mem_unit against an arithmetic reference model.
// Latency: checks XLEN+2 stall cycles and the DONE pulse position per request.
// Backpressure: holds each request until the cycle after DONE, as a stalled pipeline would.
module tb_mac_mem_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mac_mem_unit_if #(.XLEN(32)) bus ();

    mac_mem_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .mac (bus)
    );

    always #5 clk = ~clk;

    int     vecs = 0;
    int     errs = 0;
    longint acc_m = 0;
    bit     ovf_m = 1'b0;

    logic [31:0] corners [5] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h1};

    // Reference: plain signed arithmetic on 64-bit integers
    function automatic void model_apply(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
`ifdef MAC_SATURATE_EN
        logic signed [64:0] wide;
        logic signed [64:0] smax;
        logic signed [64:0] smin;
`endif
        p = longint'($signed(a)) * longint'($signed(b));
        case (op)
            2'd1: acc_m = p;
            2'd2: begin
`ifdef MAC_SATURATE_EN
                smax = 65'sh0_7FFF_FFFF_FFFF_FFFF;
                smin = 65'sh1_8000_0000_0000_0000;
                wide = {acc_m[63], acc_m} + {p[63], p};
                if (wide > smax) begin
                    acc_m = 64'h7FFF_FFFF_FFFF_FFFF;
                    ovf_m = 1'b1;
                end else if (wide < smin) begin
                    acc_m = 64'h8000_0000_0000_0000;
                    ovf_m = 1'b1;
                end else begin
                    acc_m = wide[63:0];
                end
`else
                acc_m = acc_m + p;
`endif
            end
            2'd3: begin
                acc_m = 0;
                ovf_m = 1'b0;
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 3) == 0)
            return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Issue one MUL/MACC right after a rising edge; returns one edge after DONE
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int          stall_cnt = 0;
        int          done_cyc  = 0;
        bit          busy_bad  = 1'b0;
        logic [63:0] acc_at_done = '0;
        bus.mac_write_m = 1'b1;
        bus.mac_op_m    = op;
        bus.src_a_m     = a;
        bus.src_b_m     = b;
        for (int cyc = 1; cyc <= 60 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            if (bus.mac_stall) stall_cnt++;
            if (cyc >= 2 && !bus.mac_busy) busy_bad = 1'b1;
            if (bus.mac_done) begin
                done_cyc    = cyc;
                acc_at_done = bus.mac_acc;
            end
            @(posedge clk); #1;
        end
        bus.mac_write_m = 1'b0;
        bus.mac_op_m    = 2'd0;
        model_apply(op, a, b);

        vecs++;
        if (done_cyc !== 35) begin
            errs++;
            $display("FAIL done_cycle op=%0d a=%h b=%h: got %0d, want 35", op, a, b, done_cyc);
        end
        vecs++;
        if (stall_cnt !== 34) begin
            errs++;
            $display("FAIL stall_cycles op=%0d a=%h b=%h: got %0d, want 34", op, a, b, stall_cnt);
        end
        vecs++;
        if (busy_bad) begin
            errs++;
            $display("FAIL busy op=%0d a=%h b=%h: busy dropped before DONE, want 1", op, a, b);
        end
        vecs++;
        if (acc_at_done !== acc_m) begin
            errs++;
            $display("FAIL acc_in_done op=%0d a=%h b=%h: got %h, want %h", op, a, b, acc_at_done, acc_m);
        end
        @(negedge clk);
        vecs++;
        if (bus.mac_acc !== acc_m || bus.mac_ovf !== ovf_m || bus.mac_busy !== 1'b0) begin
            errs++;
            $display("FAIL after_done op=%0d: acc=%h ovf=%b busy=%b, want acc=%h ovf=%b busy=0",
                     op, bus.mac_acc, bus.mac_ovf, bus.mac_busy, acc_m, ovf_m);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_clr();
        bus.mac_write_m = 1'b1;
        bus.mac_op_m    = 2'd3;
        @(negedge clk);
        vecs++;
        if (bus.mac_stall !== 1'b0) begin
            errs++;
            $display("FAIL clr_stall: got %b, want 0", bus.mac_stall);
        end
        @(posedge clk); #1;
        bus.mac_write_m = 1'b0;
        bus.mac_op_m    = 2'd0;
        model_apply(2'd3, 32'h0, 32'h0);
        @(negedge clk);
        vecs++;
        if (bus.mac_acc !== 64'h0 || bus.mac_ovf !== 1'b0 || bus.mac_busy !== 1'b0 || bus.mac_done !== 1'b0) begin
            errs++;
            $display("FAIL clr_result: acc=%h ovf=%b busy=%b done=%b, want 0 0 0 0",
                     bus.mac_acc, bus.mac_ovf, bus.mac_busy, bus.mac_done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mac_write_m = 1'b1;
        bus.mac_op_m    = 2'd1;
        bus.src_a_m     = 32'd5;
        bus.src_b_m     = 32'd6;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vecs++;
        if (bus.mac_acc !== 64'h0 || bus.mac_ovf !== 1'b0 || bus.mac_busy !== 1'b0 ||
            bus.mac_done !== 1'b0 || bus.mac_stall !== 1'b0) begin
            errs++;
            $display("FAIL reset_state: acc=%h ovf=%b busy=%b done=%b stall=%b, want all 0",
                     bus.mac_acc, bus.mac_ovf, bus.mac_busy, bus.mac_done, bus.mac_stall);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mac_write_m = 1'b0;
        bus.mac_op_m    = 2'd0;
        acc_m = 0;
        ovf_m = 1'b0;
    endtask

    task automatic test_directed();
        run_op(2'd1, 32'd3, 32'd4);
        vecs++;
        if (bus.mac_acc !== 64'd12) begin
            errs++;
            $display("FAIL mul_3x4: got %h, want 000000000000000c", bus.mac_acc);
        end
        run_op(2'd2, -32'sd7, 32'sd5);
        vecs++;
        if (bus.mac_acc !== 64'hFFFF_FFFF_FFFF_FFE9) begin
            errs++;
            $display("FAIL macc_m7x5: got %h, want ffffffffffffffe9", bus.mac_acc);
        end
        run_op(2'd1, 32'h8000_0000, 32'h8000_0000);
        vecs++;
        if (bus.mac_acc !== 64'h4000_0000_0000_0000) begin
            errs++;
            $display("FAIL mul_min_min: got %h, want 4000000000000000", bus.mac_acc);
        end
    endtask

    task automatic test_clr();
        do_clr();
    endtask

    task automatic test_overflow();
        run_op(2'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        repeat (3) run_op(2'd2, 32'h8000_0000, 32'h8000_0000);
        do_clr();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 7) == 0)
                do_clr();
            else
                run_op(($urandom_range(0, 2) == 0) ? 2'd1 : 2'd2, pick_operand(), pick_operand());
        end
    endtask

    task automatic test_reset_mid();
        run_op(2'd1, 32'd1000, 32'd1000);
        bus.mac_write_m = 1'b1;
        bus.mac_op_m    = 2'd2;
        bus.src_a_m     = 32'd123;
        bus.src_b_m     = 32'd456;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.mac_write_m = 1'b0;
        bus.mac_op_m    = 2'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        acc_m = 0;
        ovf_m = 1'b0;
        @(negedge clk);
        vecs++;
        if (bus.mac_acc !== 64'h0 || bus.mac_stall !== 1'b0 || bus.mac_busy !== 1'b0 || bus.mac_done !== 1'b0) begin
            errs++;
            $display("FAIL reset_mid_mul: acc=%h stall=%b busy=%b done=%b, want all 0",
                     bus.mac_acc, bus.mac_stall, bus.mac_busy, bus.mac_done);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vecs++;
            if (bus.mac_done !== 1'b0 || bus.mac_acc !== 64'h0) begin
                errs++;
                $display("FAIL reset_mid_quiet cycle %0d: done=%b acc=%h, want 0 0", i, bus.mac_done, bus.mac_acc);
            end
        end
        @(posedge clk); #1;
        run_op(2'd2, -32'sd2, 32'sd9);
    endtask

    initial begin
        bus.mac_write_m = 1'b0;
        bus.mac_op_m    = 2'd0;
        bus.src_a_m     = '0;
        bus.src_b_m     = '0;
        test_reset();
        test_directed();
        test_clr();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
